seven_seg_scanner: RTL and testbench
====================================

# seven_seg_scanner

Time-multiplexed controller for a 4-digit common-anode seven-segment display. It accepts a 14-bit binary value through a load/ready handshake and converts it to BCD with a sequential shift-add-3 engine. It then scans the four digits through a single shared instance of the team's BCD-to-segment decoder, blanking leading zeros. It sits between the CPU's debug/output register and the board display pins.

## Interface

- `REFRESH_DIV`, default 50000: clock cycles each digit stays lit; minimum 2.
- `BLANK_LEADING`, default 1: 1 blanks leading zeros; 0 shows all four digits.

- `clk`  in  1: system clock.
- `rst_n`  in  1: reset, asynchronous and active-low.
- `value`  in  14: binary value to display; 0..9999 is the valid range.
- `load`  in  1: request to capture `value`; accepted only when `ready`=1.
- `ready`  out  1: 1 = idle, able to accept `load`.
- `seg`  out  7: segment drive, active-low, bit order {g,f,e,d,c,b,a}; registered.
- `an`  out  4: digit enables, active-low one-hot; `an[0]` = least significant digit; registered.

## Operation

- Reset values:
  - `ready`=1, `an`=4'b1111, `seg`=7'b1111111.
  - Digit registers all 0; scan index 0; divider 0; FSM in IDLE.
- Conversion FSM:
  - IDLE: `load`&`ready` latches `value`, clears the BCD shift register, sets iteration count 0, goes to CONV, and drops `ready`.
  - CONV: one double-dabble iteration per cycle. Any BCD nibble ≥5 gets +3, then {bcd,bin} shifts left by 1. Exactly 14 cycles, then COMMIT.
  - COMMIT: one cycle. Writes the four BCD nibbles into the display digit registers, returns to IDLE, and sets `ready`=1.
- Range:
  - Latched value >9999: COMMIT writes 4'hF to all four digits. The decoder outputs OFF for 4'hF, so the display goes fully dark.
  - Latency is identical for in-range and out-of-range values.
- `load` while `ready`=0 is ignored; no queueing.
- Display digits change only in COMMIT, so the display never shows a partially converted value. Scanning continues from the old digits during CONV.
- Scan:
  - Divider counts 0..REFRESH_DIV-1.
  - On the terminal count, the scan index advances 0→1→2→3→0 and the divider wraps to 0.
- Blanking, when BLANK_LEADING=1:
  - Digit i>0 is blanked (4'hF fed to the decoder) iff digits i..3 are all 0.
  - Digit 0 is never blanked, so value 0 shows a single "0".
  - The 4'hF overflow pattern is unaffected by blanking.
- Output registers update every cycle:
  - `an` <= ~(1<<index).
  - `seg` <= decode(shown digit of index).
- Reset asserted mid-conversion aborts immediately to reset values; no commit occurs.

## Timing

- `load` accepted at edge k:
  - `ready`=0 from k through k+14.
  - COMMIT executes at edge k+15; `ready`=1 after k+15, so a new `load` can be accepted at edge k+16.
  - New digit pattern appears on `seg` at the first edge after k+15 at which `an` selects that digit. Worst case: k+16+3·REFRESH_DIV.
- First edge after reset release: `an`=4'b1110, `seg`=7'b1000000 ("0").
- Index change and the matching `seg` change land on the same edge; no cycle with mismatched `an`/`seg`.
- Per-digit dwell is exactly REFRESH_DIV cycles; full frame is 4·REFRESH_DIV.

## Structure

- Shared package:
  - `SEG_OFF`=4'hF blank code.
  - `NUM_DIGITS`=4, `BIN_W`=14, `MAX_VAL`=9999.
  - FSM state encoding {IDLE, CONV, COMMIT}.
- Sub-module: one instance of the existing `Seven_Segment_Display` decoder, fed by the scan mux.
- Conversion FSM, divider/scan counter and blanking logic live in this module.

## Test plan

All scenarios use REFRESH_DIV=4, BLANK_LEADING=1 unless noted.

- Reset, then observe 16 cycles → `an` cycles 1110,1101,1011,0111 with 4-cycle dwell. `seg`=1000000 on digit 0; the other digits show 1111111.
- `load` with `value`=1234 → `ready` low exactly 15 cycles. After commit, digits 3..0 show 1111001, 0100100, 0110000, 0011001.
- `value`=907, then `value`=7 → first shows digit 3 blank, then 1111001-free pattern 0010000, 1000000, 1111000. Second shows only digit 0 = 1111000.
- `value`=10000 → all four digits 1111111 after commit; `ready` timing unchanged.
- `load` pulsed during CONV with a different value → ignored; the first value is committed.
- `rst_n` low at CONV cycle 7 after loading 4321 → outputs return to reset values, display shows "0", `ready`=1.
- BLANK_LEADING=0, `value`=5 → digits 3..0 show 0,0,0,5.

Source files
------------

// File: rtl/seven_seg_scanner_pkg.sv
// Shared constants, FSM encoding and BCD helper
// for the seven-segment scanner.
package seven_seg_scanner_pkg;

  localparam int NUM_DIGITS = 4;
  localparam int BIN_W = 14;
  localparam int BCD_W = 4 * NUM_DIGITS;
  localparam int MAX_VAL = 9999;
  localparam logic [3:0] SEG_OFF = 4'hF;

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    COMMIT
  } state_t;

  // add-3 correction applied before each double-dabble shift
  function automatic logic [BCD_W-1:0] dd_adj(
    input logic [BCD_W-1:0] b
  );
    logic [BCD_W-1:0] r;
    r = b;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (r[4*i+:4] >= 4'd5)
        r[4*i+:4] = r[4*i+:4] + 4'd3;
    end
    return r;
  endfunction

endpackage

// File: rtl/seven_seg_scanner_decoder.sv
// BCD to active-low segment decoder, {g,f,e,d,c,b,a}.
// Codes above 9 (including the blank code) turn all segments off.
module Seven_Segment_Display (
  input  logic [3:0] i_bcd,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = 7'b1111111;
    case (i_bcd)
      4'd0: o_seg = 7'b1000000;
      4'd1: o_seg = 7'b1111001;
      4'd2: o_seg = 7'b0100100;
      4'd3: o_seg = 7'b0110000;
      4'd4: o_seg = 7'b0011001;
      4'd5: o_seg = 7'b0010010;
      4'd6: o_seg = 7'b0000010;
      4'd7: o_seg = 7'b1111000;
      4'd8: o_seg = 7'b0000000;
      4'd9: o_seg = 7'b0010000;
      default: o_seg = 7'b1111111;
    endcase
  end

endmodule

// File: rtl/seven_seg_scanner.sv
// 4-digit multiplexed seven-segment controller with a sequential
// double-dabble converter and leading-zero blanking.
module seven_seg_scanner
  import seven_seg_scanner_pkg::*;
#(
  parameter int REFRESH_DIV = 50000,
  parameter int BLANK_LEADING = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [13:0] value,
  input  logic        load,
  output logic        ready,
  output logic [6:0]  seg,
  output logic [3:0]  an
);

  localparam int DIV_W = $clog2(REFRESH_DIV);

  state_t r_state;
  state_t w_next;

  logic [BIN_W-1:0] r_bin;
  logic [BCD_W-1:0] r_bcd;
  logic [BCD_W-1:0] w_dd;
  logic [3:0]       r_iter;
  logic             r_ovf;

  logic [NUM_DIGITS-1:0][3:0] r_dig;
  logic [DIV_W-1:0]           r_div;
  logic [1:0]                 r_idx;

  logic [NUM_DIGITS-1:0] w_zero;
  logic                  w_blank;
  logic [3:0]            w_shown;
  logic [6:0]            w_seg;

  assign ready = (r_state == IDLE);
  assign w_dd  = dd_adj(r_bcd);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (load) w_next = CONV;
      CONV:    if (r_iter == 4'(BIN_W - 1)) w_next = COMMIT;
      COMMIT:  w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bin  <= '0;
      r_bcd  <= '0;
      r_iter <= '0;
      r_ovf  <= 1'b0;
      r_dig  <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (load) begin
            r_bin  <= value;
            r_bcd  <= '0;
            r_iter <= '0;
            r_ovf  <= (value > 14'(MAX_VAL));
          end
        end
        CONV: begin
          {r_bcd, r_bin} <= {w_dd[BCD_W-2:0], r_bin, 1'b0};
          r_iter <= r_iter + 4'd1;
        end
        COMMIT: begin
          r_dig <= r_ovf ? {NUM_DIGITS{SEG_OFF}} : r_bcd;
        end
        default: ;
      endcase
    end
  end

  // w_zero[i]: digits i..3 are all zero
  always_comb begin
    w_zero = '0;
    w_zero[NUM_DIGITS-1] = (r_dig[NUM_DIGITS-1] == 4'd0);
    for (int i = NUM_DIGITS - 2; i >= 0; i--)
      w_zero[i] = w_zero[i+1] && (r_dig[i] == 4'd0);
  end

  assign w_blank = (BLANK_LEADING != 0) &&
                   (r_idx != 2'd0) && w_zero[r_idx];
  assign w_shown = w_blank ? SEG_OFF : r_dig[r_idx];

  Seven_Segment_Display u_dec (
    .i_bcd (w_shown),
    .o_seg (w_seg)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div <= '0;
      r_idx <= '0;
      an    <= 4'b1111;
      seg   <= 7'b1111111;
    end else begin
      if (r_div == DIV_W'(REFRESH_DIV - 1)) begin
        r_div <= '0;
        r_idx <= r_idx + 2'd1;
      end else begin
        r_div <= r_div + 1'b1;
      end
      an  <= ~(4'b0001 << r_idx);
      seg <= w_seg;
    end
  end

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Bench: directed and random loads against a decimal-arithmetic
// display model, with and without leading-zero blanking.
module tb_seven_seg_scanner;

  localparam int RD = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load = 1'b0;
  logic [13:0] value = '0;

  logic       ready_b, ready_n;
  logic [6:0] seg_b, seg_n;
  logic [3:0] an_b, an_n;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int m_cnt = 0;
  int m_val = 0;
  int m_pend = 0;

  logic [6:0] segtab [0:9];

  always #5 clk = ~clk;

  seven_seg_scanner #(.REFRESH_DIV(RD), .BLANK_LEADING(1)) u_b (
    .clk(clk), .rst_n(rst_n), .value(value), .load(load),
    .ready(ready_b), .seg(seg_b), .an(an_b)
  );

  seven_seg_scanner #(.REFRESH_DIV(RD), .BLANK_LEADING(0)) u_n (
    .clk(clk), .rst_n(rst_n), .value(value), .load(load),
    .ready(ready_n), .seg(seg_n), .an(an_n)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] exp_seg(input int blank,
                                         input int idx);
    int p = 1;
    for (int i = 0; i < idx; i++) p = p * 10;
    if (m_val > 9999) return 7'h7F;
    if (blank != 0 && idx > 0 && m_val < p) return 7'h7F;
    return segtab[(m_val / p) % 10];
  endfunction

  task automatic step();
    bit commit;
    int idx;
    logic [3:0] exp_an;
    @(posedge clk);
    cyc++;
    commit = 0;
    if (m_cnt == 0) begin
      if (load) begin
        m_cnt  = 15;
        m_pend = int'(value);
      end
    end else begin
      m_cnt--;
      if (m_cnt == 0) commit = 1;
    end
    @(negedge clk);
    idx = ((cyc - 1) / RD) % 4;
    exp_an = ~(4'b0001 << idx);
    chk("ready_b", 32'(ready_b), 32'(m_cnt == 0));
    chk("ready_n", 32'(ready_n), 32'(m_cnt == 0));
    chk("an_b", 32'(an_b), 32'(exp_an));
    chk("an_n", 32'(an_n), 32'(exp_an));
    chk("seg_b", 32'(seg_b), 32'(exp_seg(1, idx)));
    chk("seg_n", 32'(seg_n), 32'(exp_seg(0, idx)));
    if (commit) m_val = m_pend;
  endtask

  task automatic do_load(input int v, input int extra);
    value = 14'(v);
    load = 1'b1;
    step();
    load = 1'b0;
    repeat (14 + extra) step();
  endtask

  task automatic chk_reset();
    chk("rst_an_b", 32'(an_b), 32'hF);
    chk("rst_seg_b", 32'(seg_b), 32'h7F);
    chk("rst_rdy_b", 32'(ready_b), 32'h1);
    chk("rst_an_n", 32'(an_n), 32'hF);
    chk("rst_seg_n", 32'(seg_n), 32'h7F);
    chk("rst_rdy_n", 32'(ready_n), 32'h1);
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n = 1'b1;
    cyc = 0;
    m_cnt = 0;
    m_val = 0;
  endtask

  initial begin
    segtab[0] = 7'b1000000; segtab[1] = 7'b1111001;
    segtab[2] = 7'b0100100; segtab[3] = 7'b0110000;
    segtab[4] = 7'b0011001; segtab[5] = 7'b0010010;
    segtab[6] = 7'b0000010; segtab[7] = 7'b1111000;
    segtab[8] = 7'b0000000; segtab[9] = 7'b0010000;

    repeat (3) @(negedge clk);
    chk_reset();
    release_reset();
    repeat (16) step();

    do_load(1234, 20);
    do_load(907, 20);
    do_load(7, 20);
    do_load(10000, 20);
    do_load(5, 20);
    do_load(0, 18);
    do_load(9999, 18);

    // load during conversion must be dropped
    value = 14'd4000;
    load = 1'b1;
    step();
    value = 14'd8888;
    repeat (6) step();
    load = 1'b0;
    repeat (26) step();

    // reset in the middle of a conversion
    value = 14'd4321;
    load = 1'b1;
    step();
    load = 1'b0;
    repeat (7) step();
    rst_n = 1'b0;
    #1;
    chk_reset();
    release_reset();
    repeat (20) step();

    for (int n = 0; n < 400; n++) begin
      value = 14'($urandom_range(0, 12000));
      load = ($urandom_range(0, 5) == 0);
      step();
    end
    load = 1'b0;
    repeat (20) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
